// File: rtl/wb_async_mem_initiator.sv
// Wishbone classic slave that replays each WB cycle as one
// fixed-timing async SRAM bus cycle (cs_n/oe_n/we_n/bls_n).
module wb_async_mem_initiator #(
  parameter int AW     = 24,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1,
  parameter int TURN   = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_d_o,
  input  logic [31:0]   mem_d_i,
  output logic          mem_d_oe,
  output logic          mem_cs_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic [3:0]    mem_bls_n
);

  localparam int M1   = (SETUP > STROBE) ? SETUP : STROBE;
  localparam int M2   = (HOLD > TURN) ? HOLD : TURN;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  generate
    if (STROBE < 1) begin : g_bad_strobe
      $fatal(1, "STROBE must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK,
    S_TURN
  } state_e;

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] a_q, a_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [31:0]   do_q, do_d;
  logic [31:0]   dat_q, dat_d;
  logic          ack_q, ack_d;
  logic          cs_n_q, cs_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic [3:0]    bls_n_q, bls_n_d;
  logic          doe_q, doe_d;

  logic accept, last, busy;

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  assign accept = wb_cyc_i & wb_stb_i;
  assign last   = (cnt_q == '0);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    sel_d = sel_q;
    we_d  = we_q;
    do_d  = do_q;
    dat_d = dat_q;

    // Request is latched only when an access can actually start.
    unique case (st_q)
      S_IDLE: begin
        if (accept) begin
          st_d = (SETUP > 0) ? S_SETUP : S_STROBE;
        end
      end
      S_SETUP: begin
        if (last) st_d = S_STROBE;
      end
      S_STROBE: begin
        if (last) begin
          if (!we_q) dat_d = mem_d_i;
          st_d = (HOLD > 0) ? S_HOLD : S_ACK;
        end
      end
      S_HOLD: begin
        if (last) st_d = S_ACK;
      end
      S_ACK: begin
        st_d = (TURN > 0) ? S_TURN : S_IDLE;
      end
      S_TURN: begin
        if (last) begin
          if (accept) begin
            st_d = (SETUP > 0) ? S_SETUP : S_STROBE;
          end else begin
            st_d = S_IDLE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase

    if ((st_q == S_IDLE || st_q == S_TURN) &&
        (st_d == S_SETUP || st_d == S_STROBE)) begin
      a_d   = wb_adr_i[AW+1:2];
      sel_d = wb_sel_i;
      we_d  = wb_we_i;
      do_d  = wb_dat_i;
    end

    if (st_d != st_q) begin
      unique case (st_d)
        S_SETUP:  cnt_d = CW'(SETUP > 0 ? SETUP - 1 : 0);
        S_STROBE: cnt_d = CW'(STROBE - 1);
        S_HOLD:   cnt_d = CW'(HOLD > 0 ? HOLD - 1 : 0);
        S_TURN:   cnt_d = CW'(TURN > 0 ? TURN - 1 : 0);
        default:  cnt_d = '0;
      endcase
    end else if (!last) begin
      cnt_d = cnt_q - 1'b1;
    end

    busy    = (st_d == S_SETUP) || (st_d == S_STROBE) ||
              (st_d == S_HOLD);
    cs_n_d  = ~busy;
    oe_n_d  = ~((st_d == S_STROBE) && !we_d);
    we_n_d  = ~((st_d == S_STROBE) && we_d);
    bls_n_d = busy ? ~sel_d : 4'hF;
    doe_d   = busy & we_d;
    ack_d   = (st_d == S_ACK) && (st_q != S_ACK) && wb_cyc_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      do_q    <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bls_n_q <= 4'hF;
      doe_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      do_q    <= do_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      bls_n_q <= bls_n_d;
      doe_q   <= doe_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign mem_a     = a_q;
  assign mem_d_o   = do_q;
  assign mem_d_oe  = doe_q;
  assign mem_cs_n  = cs_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_bls_n = bls_n_q;

endmodule
